// File: rtl/layer4_act_packer.sv
// layer4_act_packer: packs the Layer-3 activation stream into 128-bit FC words.
// Optional LAYER4_PACK_RELU_EN clamps negative elements to zero on accept.
module layer4_act_packer #(
   parameter int DATA_W    = 16,
   parameter int LANES     = 8,
   parameter int FRAME_LEN = 196
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic [DATA_W-1:0]       s_act_TDATA,
   input  logic                    s_act_TVALID,
   output logic                    s_act_TREADY,
   output logic [LANES*DATA_W-1:0] a_Data_TDATA,
   output logic                    a_Data_TVALID,
   input  logic                    a_Data_TREADY,
   output logic                    frame_done
);

   localparam int WORD_W = LANES * DATA_W;
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [LIDX_W-1:0] LANE_MAX = LIDX_W'(LANES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FRAME_LEN - 1);

   logic [LIDX_W-1:0] lane_idx;
   logic [CNT_W-1:0]  elem_cnt;
   logic [WORD_W-1:0] asm_data;
   logic              asm_full;
   logic              asm_last;
   logic [WORD_W-1:0] out_data;
   logic              out_valid;
   logic              out_last;
   logic              done;

   logic              accept;
   logic              out_free;
   logic              out_hs;
   logic              last_elem;
   logic              close;
   logic [DATA_W-1:0] elem;
   logic [WORD_W-1:0] fill;

   logic [WORD_W-1:0] asm_data_d;
   logic              asm_full_d;
   logic              asm_last_d;
   logic [WORD_W-1:0] out_data_d;
   logic              out_valid_d;
   logic              out_last_d;

   // A held word blocks further input until it moves to the output.
   assign s_act_TREADY = ap_rst_n & ~asm_full;
   assign accept       = s_act_TVALID & s_act_TREADY;
   assign out_free     = ~out_valid | a_Data_TREADY;
   assign out_hs       = out_valid & a_Data_TREADY;
   assign last_elem    = (elem_cnt == CNT_MAX);
   assign close        = accept & ((lane_idx == LANE_MAX) | last_elem);

   assign a_Data_TDATA  = out_data;
   assign a_Data_TVALID = out_valid;
   assign frame_done    = done;

   // Element conditioning on the way into the assembly lanes.
   always_comb begin
      elem = s_act_TDATA;
`ifdef LAYER4_PACK_RELU_EN
      if (s_act_TDATA[DATA_W-1]) begin
         elem = '0;
      end
`endif
   end

   // Assembly word with the incoming element dropped into its lane.
   always_comb begin
      fill = asm_data;
      for (int i = 0; i < LANES; i++) begin
         if (lane_idx == LIDX_W'(i)) begin
            fill[i*DATA_W +: DATA_W] = elem;
         end
      end
   end

   // Word movement between assembly and output registers.
   always_comb begin
      asm_data_d  = asm_data;
      asm_full_d  = asm_full;
      asm_last_d  = asm_last;
      out_data_d  = out_data;
      out_valid_d = out_valid & ~a_Data_TREADY;
      out_last_d  = out_last;
      if (asm_full) begin
         if (out_free) begin
            out_data_d  = asm_data;
            out_valid_d = 1'b1;
            out_last_d  = asm_last;
            asm_data_d  = '0;
            asm_full_d  = 1'b0;
            asm_last_d  = 1'b0;
         end
      end else if (close) begin
         if (out_free) begin
            out_data_d  = fill;
            out_valid_d = 1'b1;
            out_last_d  = last_elem;
            asm_data_d  = '0;
         end else begin
            asm_data_d  = fill;
            asm_full_d  = 1'b1;
            asm_last_d  = last_elem;
         end
      end else if (accept) begin
         asm_data_d = fill;
      end
   end

   // Assembly and output registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         asm_data  <= '0;
         asm_full  <= 1'b0;
         asm_last  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         asm_data  <= asm_data_d;
         asm_full  <= asm_full_d;
         asm_last  <= asm_last_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
         out_last  <= out_last_d;
      end
   end

   // Lane and frame position, advanced on every accepted element.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         lane_idx <= '0;
         elem_cnt <= '0;
      end else if (accept) begin
         lane_idx <= close ? '0 : lane_idx + 1'b1;
         elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
      end
   end

   // Frame completion pulse after the last word is taken downstream.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         done <= 1'b0;
      end else begin
         done <= out_hs & out_last;
      end
   end

endmodule

// File: tb/tb_layer4_act_packer.sv
// tb_layer4_act_packer: scoreboard bench for layer4_act_packer.
// Define LAYER4_PACK_RELU_EN for both DUT and bench to check the clamp build.
module tb_layer4_act_packer;

   logic         ap_clk = 1'b0;
   logic         ap_rst_n = 1'b0;
   logic [15:0]  s_act_TDATA = '0;
   logic         s_act_TVALID = 1'b0;
   logic         s_act_TREADY;
   logic [127:0] a_Data_TDATA;
   logic         a_Data_TVALID;
   logic         a_Data_TREADY = 1'b0;
   logic         frame_done;

   layer4_act_packer dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .s_act_TDATA   (s_act_TDATA),
      .s_act_TVALID  (s_act_TVALID),
      .s_act_TREADY  (s_act_TREADY),
      .a_Data_TDATA  (a_Data_TDATA),
      .a_Data_TVALID (a_Data_TVALID),
      .a_Data_TREADY (a_Data_TREADY),
      .frame_done    (frame_done)
   );

   always #5 ap_clk = ~ap_clk;

   int tests = 0;
   int fails = 0;

   logic [127:0] exp_q[$];
   bit           last_q[$];

   logic [127:0] m_word = '0;
   int           m_lane = 0;
   int           m_pos  = 0;

   int rdy_mode = 0;
   bit rdy_hold = 1'b0;

   int cyc = 0;
   int accepted = 0;
   int stall_cyc = 0;
   int fd_pulses = 0;
   int hs_cnt = 0;
   int first_hs = -1;
   int last_hs = -1;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_elem(input logic [15:0] x);
`ifdef LAYER4_PACK_RELU_EN
      if ($signed(x) < 0) return 16'h0000;
`endif
      return x;
   endfunction

   // Reference: frames of 196 elements, 8 per word, short last word zero-padded.
   task automatic model_push(input logic [15:0] x);
      bit lst;
      m_word[m_lane*16 +: 16] = ref_elem(x);
      m_lane++;
      m_pos++;
      lst = (m_pos == 196);
      if (m_lane == 8 || lst) begin
         exp_q.push_back(m_word);
         last_q.push_back(lst);
         m_word = '0;
         m_lane = 0;
         if (lst) m_pos = 0;
      end
   endtask

   task automatic model_clear();
      m_word = '0;
      m_lane = 0;
      m_pos  = 0;
   endtask

   initial forever begin
      @(posedge ap_clk);
      cyc++;
   end

   initial forever begin
      @(posedge ap_clk);
      #2;
      case (rdy_mode)
         0: a_Data_TREADY = 1'b1;
         1: a_Data_TREADY = ($urandom % 4) != 0;
         default: a_Data_TREADY = rdy_hold;
      endcase
   end

   bit           fd_exp = 1'b0;
   bit           prev_stall = 1'b0;
   logic [127:0] prev_data = '0;

   initial forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
         fd_exp = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("frame_done", frame_done, fd_exp);
         if (frame_done) fd_pulses++;
         if (prev_stall) begin
            check("hold_valid", a_Data_TVALID, 1);
            check("hold_data", a_Data_TDATA, prev_data);
         end
         fd_exp = 1'b0;
         if (a_Data_TVALID && a_Data_TREADY) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_word: got %h, none expected", a_Data_TDATA);
            end else begin
               check("word", a_Data_TDATA, exp_q.pop_front());
               fd_exp = last_q.pop_front();
            end
         end
         prev_stall = a_Data_TVALID && !a_Data_TREADY;
         prev_data  = a_Data_TDATA;
      end
   end

   task automatic put(input logic [15:0] x, input int gap);
      int t;
      s_act_TVALID = 1'b0;
      repeat (gap) @(negedge ap_clk);
      s_act_TVALID = 1'b1;
      s_act_TDATA  = x;
      model_push(x);
      t = 0;
      while (!s_act_TREADY && t < 300) begin
         @(negedge ap_clk);
         t++;
         stall_cyc++;
      end
      if (!s_act_TREADY) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got no accept, required accept of %h", x);
      end
      @(negedge ap_clk);
      accepted++;
      s_act_TVALID = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || a_Data_TVALID) && t < 2000) begin
         @(negedge ap_clk);
         t++;
      end
      check("drain_empty", exp_q.size(), 0);
      repeat (3) @(negedge ap_clk);
   endtask

   task automatic start_stats();
      stall_cyc = 0;
      hs_cnt = 0;
      first_hs = -1;
      last_hs = -1;
   endtask

   task automatic seq_frame();
      int fd0;
      start_stats();
      fd0 = fd_pulses;
      for (int i = 1; i <= 196; i++) put(16'(i), 0);
      drain();
      check("s2_words", hs_cnt, 25);
      check("s2_frame_done", fd_pulses - fd0, 1);
      check("s2_no_stall", stall_cyc, 0);
      check("s2_span", last_hs - first_hs, 188);
   endtask

   initial begin
      int fd0;
      int a0;
      s_act_TVALID = 1'b1;
      s_act_TDATA  = 16'h1234;
      rdy_mode = 0;
      repeat (3) @(negedge ap_clk);
      check("rst_tready", s_act_TREADY, 0);
      check("rst_valid", a_Data_TVALID, 0);
      check("rst_data", a_Data_TDATA, 0);
      check("rst_done", frame_done, 0);
      ap_rst_n = 1'b1;
      s_act_TVALID = 1'b0;
      @(negedge ap_clk);
      check("rel_tready", s_act_TREADY, 1);

      seq_frame();

      start_stats();
      fd0 = fd_pulses;
      a0 = accepted;
      rdy_hold = 1'b0;
      rdy_mode = 2;
      fork
         for (int i = 1; i <= 196; i++) put(16'(i), 0);
         begin
            repeat (25) @(negedge ap_clk);
            check("bp_tready", s_act_TREADY, 0);
            check("bp_accepted", accepted - a0, 16);
            rdy_mode = 0;
         end
      join
      drain();
      check("bp_words", hs_cnt, 25);
      check("bp_frame_done", fd_pulses - fd0, 1);

      start_stats();
      fd0 = fd_pulses;
      for (int i = 1; i <= 392; i++) put(16'(i), 0);
      drain();
      check("two_words", hs_cnt, 50);
      check("two_frame_done", fd_pulses - fd0, 2);

      for (int i = 1; i <= 13; i++) put(16'(i), 0);
      repeat (3) @(negedge ap_clk);
      check("pre_rst_q", exp_q.size(), 0);
      ap_rst_n = 1'b0;
      s_act_TVALID = 1'b1;
      model_clear();
      repeat (2) @(negedge ap_clk);
      check("mid_rst_valid", a_Data_TVALID, 0);
      check("mid_rst_tready", s_act_TREADY, 0);
      ap_rst_n = 1'b1;
      s_act_TVALID = 1'b0;
      @(negedge ap_clk);
      seq_frame();

      start_stats();
      fd0 = fd_pulses;
      rdy_mode = 1;
      for (int f = 0; f < 2; f++) begin
         put(16'hFFF0, 0);
         for (int i = 1; i < 196; i++)
            put(16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
      end
      rdy_mode = 0;
      drain();
      check("rnd_words", hs_cnt, 50);
      check("rnd_frame_done", fd_pulses - fd0, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
